// File: rtl/or_logic_pipe_pkg.sv
// Shared types and the per-lane logic function for the pipelined logic unit.
package or_logic_pipe_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  // Single-lane operation; the top applies it across every bit, so any width works.
  function automatic logic logic_f(input op_e op, input logic a, input logic b);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/or_logic_pipe_if.sv
// Operand/result handshake bundle for the pipelined logic unit.
interface or_logic_pipe_if
  import or_logic_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;

  // Producer/consumer side.
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, out, zero
  );

  // Logic unit side.
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, out, zero
  );
endinterface

// File: rtl/or_logic_pipe_stage.sv
// One pipeline slot: valid bit plus result and zero flag, advanced by acc_i.
module or_logic_pipe_stage #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             acc_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             zero_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;

  // Take whatever sits upstream (beat or bubble) when allowed to advance; payload only
  // changes for a real beat, so an emptied slot keeps its last value.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    zero_d  = zero_q;
    if (acc_i) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = data_i;
        zero_d = zero_i;
      end
    end
  end

  // Slot registers; reset empties the slot and leaves a zero result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      zero_q  <= 1'b1;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign zero_o  = zero_q;

endmodule

// File: rtl/or_logic_pipe.sv
// Pipelined bitwise logic unit (AND/OR/XOR/NOR) with zero flag and full back-pressure.
module or_logic_pipe
  import or_logic_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clkpos,
  input  logic             rstn,
  input  logic             vdd,
  input  logic             vss,
  or_logic_pipe_if.slave   bus
);

  logic             pwr_ok;
  logic             run;
  logic [WIDTH-1:0] r;
  logic             r_zero;
  logic [DEPTH-1:0] v;
  logic [DEPTH:0]   acc;
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] zf;

  assign pwr_ok = vdd & ~vss;
  // Reset also holds off the input so in_ready is low while rstn is low.
  assign run    = pwr_ok & rstn;

  // Combinational op mux ahead of stage 0, applied lane by lane.
  always_comb begin
    r = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      r[i] = logic_f(bus.op, bus.a[i], bus.b[i]);
    end
    r_zero = ~|r;
  end

  // Ready chain from the output back to the input; a slot advances if empty or if the
  // slot after it advances, so bubbles collapse.
  always_comb begin
    acc        = '0;
    acc[DEPTH] = bus.out_ready;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      acc[i] = run & (~v[i] | acc[i+1]);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic             valid_in;
    logic [WIDTH-1:0] data_in;
    logic             zero_in;

    if (g == 0) begin : g_first
      assign valid_in = bus.in_valid;
      assign data_in  = r;
      assign zero_in  = r_zero;
    end else begin : g_rest
      assign valid_in = v[g-1];
      assign data_in  = data[g-1];
      assign zero_in  = zf[g-1];
    end

    or_logic_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk_i   (clkpos),
      .rst_ni  (rstn),
      .acc_i   (acc[g]),
      .valid_i (valid_in),
      .data_i  (data_in),
      .zero_i  (zero_in),
      .valid_o (v[g]),
      .data_o  (data[g]),
      .zero_o  (zf[g])
    );
  end

  assign bus.in_ready  = acc[0];
  assign bus.out_valid = v[DEPTH-1] & pwr_ok;
  assign bus.out       = data[DEPTH-1];
  assign bus.zero      = zf[DEPTH-1];

endmodule

// File: tb/tb_or_logic_pipe.sv
// Scoreboard bench for or_logic_pipe: 16/2 directed scenarios plus 1/1 and 64/4 random runs.
module tb_or_logic_pipe;
  import or_logic_pipe_pkg::*;

  typedef struct {
    logic [63:0] data;
    logic        zero;
    int          cyc;
    bit          lat;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic vdd  = 1'b1;
  logic vss  = 1'b0;
  bit   rnd_on = 1'b0;

  exp_t        sb [3][$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          n_sent0  = 0;
  bit          hold_pend [3];
  logic [63:0] hold_data [3];
  int          lat_exp   [3] = '{2, 1, 4};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  or_logic_pipe_if #(.WIDTH(16)) bus0 ();
  or_logic_pipe_if #(.WIDTH(1))  bus1 ();
  or_logic_pipe_if #(.WIDTH(64)) bus2 ();

  or_logic_pipe #(.WIDTH(16), .DEPTH(2)) u_dut0 (
    .clkpos (clk), .rstn (rstn), .vdd (vdd), .vss (vss), .bus (bus0)
  );
  or_logic_pipe #(.WIDTH(1), .DEPTH(1)) u_dut1 (
    .clkpos (clk), .rstn (rstn), .vdd (vdd), .vss (vss), .bus (bus1)
  );
  or_logic_pipe #(.WIDTH(64), .DEPTH(4)) u_dut2 (
    .clkpos (clk), .rstn (rstn), .vdd (vdd), .vss (vss), .bus (bus2)
  );

  task automatic chk(input bit ok, input string name, input logic [63:0] act,
                     input logic [63:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [63:0] ref_f(input op_e op, input logic [63:0] a,
                                         input logic [63:0] b, input int w);
    logic [63:0] res, m;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      default: res = ~(a | b);
    endcase
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return res & m;
  endfunction

  function automatic logic rdy(input int id);
    case (id)
      0:       return bus0.in_ready;
      1:       return bus1.in_ready;
      default: return bus2.in_ready;
    endcase
  endfunction

  // Output monitor: pops the scoreboard on every output transfer, checks stall stability.
  task automatic mon(input int id, input logic ov, input logic ordy, input logic [63:0] od,
                     input logic oz);
    exp_t e;
    if (!rstn) begin
      hold_pend[id] = 1'b0;
      return;
    end
    if (!(vdd & ~vss)) return;
    if (hold_pend[id]) begin
      chk(ov == 1'b1, $sformatf("hold_valid%0d", id), 64'(ov), 64'd1);
      chk(od == hold_data[id], $sformatf("hold_data%0d", id), od, hold_data[id]);
    end
    hold_pend[id] = ov & ~ordy;
    hold_data[id] = od;
    if (ov & ordy) begin
      if (sb[id].size() == 0) begin
        chk(1'b0, $sformatf("unexpected_beat%0d", id), od, 64'd0);
      end else begin
        e = sb[id].pop_front();
        chk(od == e.data, $sformatf("data%0d", id), od, e.data);
        chk(oz == e.zero, $sformatf("zero%0d", id), 64'(oz), 64'(e.zero));
        if (e.lat)
          chk(cyc - e.cyc == lat_exp[id], $sformatf("latency%0d", id),
              64'(cyc - e.cyc), 64'(lat_exp[id]));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus0.out_valid, bus0.out_ready, 64'(bus0.out), bus0.zero);
    mon(1, bus1.out_valid, bus1.out_ready, 64'(bus1.out), bus1.zero);
    mon(2, bus2.out_valid, bus2.out_ready, 64'(bus2.out), bus2.zero);
  end

  task automatic wait_accept(input int id, output bit ok);
    ok = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (rdy(id)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk(1'b0, $sformatf("accept_timeout%0d", id), 64'd0, 64'd1);
  endtask

  task automatic send0(input op_e op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] expv, input bit lat);
    bit   ok;
    exp_t e;
    bus0.op       = op;
    bus0.a        = a;
    bus0.b        = b;
    bus0.in_valid = 1'b1;
    wait_accept(0, ok);
    if (ok) begin
      e.data = 64'(expv);
      e.zero = (expv == 16'h0000);
      e.cyc  = cyc;
      e.lat  = lat;
      sb[0].push_back(e);
      n_sent0++;
    end
    @(posedge clk);
    #1;
    bus0.in_valid = 1'b0;
  endtask

  task automatic run_rand(input int id, input int n, input bit lat);
    bit          ok;
    exp_t        e;
    op_e         op;
    logic [63:0] a, b;
    int          w;
    w = (id == 1) ? 1 : 64;
    for (int k = 0; k < n; k++) begin
      op = op_e'($urandom_range(3));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      if (id == 1) begin
        a = a & 64'd1;
        b = b & 64'd1;
        bus1.op = op; bus1.a = a[0]; bus1.b = b[0]; bus1.in_valid = 1'b1;
      end else begin
        bus2.op = op; bus2.a = a; bus2.b = b; bus2.in_valid = 1'b1;
      end
      wait_accept(id, ok);
      if (ok) begin
        e.data = ref_f(op, a, b, w);
        e.zero = (e.data == 64'd0);
        e.cyc  = cyc;
        e.lat  = lat;
        sb[id].push_back(e);
      end
      @(posedge clk);
      #1;
      if (id == 1) bus1.in_valid = 1'b0;
      else         bus2.in_valid = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] bp_exp [5];
    int          base;
    bp_exp = '{16'h11EE, 16'h22DD, 16'h33CC, 16'h44BB, 16'h55AA};

    bus0.in_valid = 1'b0; bus0.op = OP_AND; bus0.a = '0; bus0.b = '0; bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.op = OP_AND; bus1.a = '0; bus1.b = '0; bus1.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.op = OP_AND; bus2.a = '0; bus2.b = '0; bus2.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk(bus0.out_valid == 1'b0, "rst_out_valid", 64'(bus0.out_valid), 64'd0);
    chk(bus0.in_ready == 1'b0, "rst_in_ready", 64'(bus0.in_ready), 64'd0);
    chk(bus0.out == 16'h0, "rst_out", 64'(bus0.out), 64'd0);
    chk(bus0.zero == 1'b1, "rst_zero", 64'(bus0.zero), 64'd1);
    rstn = 1'b1;
    #1;
    chk(bus0.in_ready == 1'b1, "rel_in_ready", 64'(bus0.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Op coverage, back to back, latency checked
    send0(OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b1);
    send0(OP_OR,  16'hF0F0, 16'h0FF0, 16'hFFF0, 1'b1);
    send0(OP_XOR, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b1);
    send0(OP_NOR, 16'hF0F0, 16'h0FF0, 16'h000F, 1'b1);
    // Zero flag
    send0(OP_AND, 16'hAAAA, 16'h5555, 16'h0000, 1'b1);
    send0(OP_OR,  16'hAAAA, 16'h5555, 16'hFFFF, 1'b1);
    repeat (4) @(posedge clk);
    #1;

    // Back-pressure: pipe fills with two beats, then input stalls
    bus0.out_ready = 1'b0;
    base = n_sent0;
    fork
      begin
        for (int i = 1; i <= 5; i++)
          send0(OP_XOR, 16'(i) * 16'h1111, 16'h00FF, bp_exp[i-1], 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk(bus0.in_ready == 1'b0, "bp_in_ready", 64'(bus0.in_ready), 64'd0);
        chk(n_sent0 - base == 2, "bp_accepted", 64'(n_sent0 - base), 64'd2);
        @(posedge clk);
        #1;
        bus0.out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;

    // Power gate with two beats in flight
    fork
      begin
        send0(OP_XOR, 16'h1234, 16'h00FF, 16'h12CB, 1'b0);
        send0(OP_OR,  16'h0F00, 16'h00F0, 16'h0FF0, 1'b0);
        send0(OP_AND, 16'hFFFF, 16'h1234, 16'h1234, 1'b0);
        send0(OP_NOR, 16'h0000, 16'h0000, 16'hFFFF, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        vss = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk(bus0.in_ready == 1'b0, "pg_in_ready", 64'(bus0.in_ready), 64'd0);
          chk(bus0.out_valid == 1'b0, "pg_out_valid", 64'(bus0.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        vss = 1'b0;
      end
    join
    repeat (6) @(posedge clk);
    #1;

    // Reset mid-stream with two beats in flight
    bus0.out_ready = 1'b0;
    send0(OP_AND, 16'hFFFF, 16'h00FF, 16'h00FF, 1'b0);
    send0(OP_OR,  16'h0001, 16'h0002, 16'h0003, 1'b0);
    rstn = 1'b0;
    #1;
    chk(bus0.out_valid == 1'b0, "mid_rst_out_valid", 64'(bus0.out_valid), 64'd0);
    chk(bus0.in_ready == 1'b0, "mid_rst_in_ready", 64'(bus0.in_ready), 64'd0);
    chk(bus0.zero == 1'b1, "mid_rst_zero", 64'(bus0.zero), 64'd1);
    for (int i = 0; i < 3; i++) sb[i].delete();
    repeat (2) @(posedge clk);
    #3;
    rstn = 1'b1;
    bus0.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk(bus0.out_valid == 1'b0, "post_rst_out_valid", 64'(bus0.out_valid), 64'd0);
    chk(bus0.zero == 1'b1, "post_rst_zero", 64'(bus0.zero), 64'd1);
    @(posedge clk);
    #1;

    // Other geometries: unstalled latency first, then random out_ready
    fork
      run_rand(1, 6, 1'b1);
      run_rand(2, 6, 1'b1);
    join
    repeat (8) @(posedge clk);
    #1;
    rnd_on = 1'b1;
    fork
      begin
        fork
          run_rand(1, 60, 1'b0);
          run_rand(2, 60, 1'b0);
        join
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          bus1.out_ready = 1'($urandom_range(1));
          bus2.out_ready = 1'($urandom_range(1));
        end
      end
    join
    bus1.out_ready = 1'b1;
    bus2.out_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk(sb[i].size() == 0, $sformatf("sb_empty%0d", i), 64'(sb[i].size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
